// File: rtl/perf_monitor_if.sv
// Bus bundle for perf_monitor: control/event inputs and counter read-back outputs.
// The master drives the control side; the monitor itself is the slave.
interface perf_monitor_if #(
  parameter int unsigned NUM_EVENTS = 2,
  parameter int unsigned CNT_WIDTH  = 32
);
  localparam int unsigned SEL_W = $clog2(NUM_EVENTS + 1);

  logic                  start_i;
  logic [NUM_EVENTS-1:0] event_i;
  logic [CNT_WIDTH-1:0]  limit_i;
  logic                  clear_i;
  logic                  snap_i;
  logic [SEL_W-1:0]      sel_i;
  logic [CNT_WIDTH-1:0]  rd_data_o;
  logic [CNT_WIDTH-1:0]  cycle_o;
  logic                  done_o;
  logic [NUM_EVENTS:0]   ovf_o;

  modport master (
    output start_i, event_i, limit_i, clear_i, snap_i, sel_i,
    input  rd_data_o, cycle_o, done_o, ovf_o
  );

  modport slave (
    input  start_i, event_i, limit_i, clear_i, snap_i, sel_i,
    output rd_data_o, cycle_o, done_o, ovf_o
  );
endinterface

// File: rtl/perf_monitor.sv
// Cycle + event performance counters with cycle limit, sticky overflow and snapshot read port.
// Define PERF_MON_SATURATE_EN to make counters saturate at all-ones instead of wrapping.
module perf_monitor #(
  parameter int unsigned NUM_EVENTS = 2,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input logic           clk_i,
  input logic           rst_i,
  perf_monitor_if.slave bus
);
  localparam int unsigned NumCnt = NUM_EVENTS + 1;
  localparam int unsigned SEL_W  = $clog2(NUM_EVENTS + 1);

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  cnt_t              cnt_q    [NumCnt];
  cnt_t              cnt_d    [NumCnt];
  cnt_t              shadow_q [NumCnt];
  cnt_t              shadow_d [NumCnt];
  cnt_t              rd_q, rd_d;
  logic [NumCnt-1:0] ovf_q, ovf_d;
  logic [NumCnt-1:0] inc;
  logic              count_en;
  cnt_t              cycle_inc;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    count_en  = 1'b0;
    cycle_inc = cnt_q[0] + CNT_WIDTH'(1);

    unique case (state_q)
      StIdle: if (bus.start_i) state_d = StRun;
      StRun: begin
        if (!bus.start_i) begin
          state_d = StIdle;
        end else if (bus.limit_i != '0 && cnt_q[0] >= bus.limit_i) begin
          // Limit lowered under the running count: stop without counting this cycle.
          state_d = StDone;
        end else begin
          count_en = 1'b1;
          if (bus.limit_i != '0 && cycle_inc == bus.limit_i) state_d = StDone;
        end
      end
      StDone: state_d = StDone;
      default: state_d = StIdle;
    endcase

    // Slot 0 is the cycle counter, which increments on every counting edge.
    inc = {bus.event_i, 1'b1} & {NumCnt{count_en}};
    for (int unsigned k = 0; k < NumCnt; k++) begin
      if (inc[k]) begin
        if (cnt_q[k] == '1) begin
          ovf_d[k] = 1'b1;
`ifdef PERF_MON_SATURATE_EN
          cnt_d[k] = cnt_q[k];
`else
          cnt_d[k] = '0;
`endif
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
        end
      end
    end

    if (bus.clear_i) begin
      for (int unsigned k = 0; k < NumCnt; k++) cnt_d[k] = '0;
      ovf_d   = '0;
      state_d = bus.start_i ? StRun : StIdle;
    end

    // Snapshot takes pre-increment, pre-clear values.
    shadow_d = bus.snap_i ? cnt_q : shadow_q;

    rd_d = '0;
    for (int unsigned k = 0; k < NumCnt; k++) begin
      if (bus.sel_i == SEL_W'(k)) rd_d = shadow_q[k];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      ovf_q   <= '0;
      rd_q    <= '0;
      for (int unsigned k = 0; k < NumCnt; k++) begin
        cnt_q[k]    <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      ovf_q    <= ovf_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign bus.rd_data_o = rd_q;
  assign bus.cycle_o   = cnt_q[0];
  assign bus.done_o    = (state_q == StDone);
  assign bus.ovf_o     = ovf_q;
endmodule

// File: tb/tb_perf_monitor.sv
// Self-checking bench for perf_monitor (NUM_EVENTS=2, CNT_WIDTH=8) with a read-back scoreboard.
// Honours PERF_MON_SATURATE_EN for the overflow expectations.
module tb_perf_monitor;
  localparam int unsigned NumEv = 2;
  localparam int unsigned CntW  = 8;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  perf_monitor_if #(.NUM_EVENTS(NumEv), .CNT_WIDTH(CntW)) bus ();

  perf_monitor #(.NUM_EVENTS(NumEv), .CNT_WIDTH(CntW)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  int      n_vec = 0;
  int      n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected read value is queued with the select and retired once the registered data appears.
  task automatic read(input logic [1:0] sel, input logic [7:0] exp, input string tag);
    rd_exp_t e;
    bus.sel_i = sel;
    sb_q.push_back('{tag: tag, exp: exp});
    tick();
    e = sb_q.pop_front();
    check(e.tag, {24'd0, bus.rd_data_o}, {24'd0, e.exp});
  endtask

  task automatic snap();
    bus.snap_i = 1'b1;
    tick();
    bus.snap_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i       = 1'b0;
    bus.start_i = 1'b1;
    bus.event_i = 2'b11;
    bus.limit_i = '0;
    bus.clear_i = 1'b0;
    bus.snap_i  = 1'b0;
    bus.sel_i   = '0;
    tick();
    tick();
    rst_i       = 1'b1;
    bus.start_i = 1'b0;
    bus.event_i = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ovf_cnt;
`ifdef PERF_MON_SATURATE_EN
    ovf_cnt = 8'd255;
`else
    ovf_cnt = 8'd4;
`endif

    // 1. Reset
    do_reset();
    check("rst_cycle", {24'd0, bus.cycle_o}, 0);
    check("rst_done", {31'd0, bus.done_o}, 0);
    check("rst_ovf", {29'd0, bus.ovf_o}, 0);
    check("rst_rd", {24'd0, bus.rd_data_o}, 0);
    read(2'd1, 8'd0, "rst_shadow1");

    // 2. Limit stop
    do_reset();
    bus.limit_i = 8'd30;
    bus.start_i = 1'b1;
    tick();
    for (int n = 1; n <= 36; n++) begin
      if (n <= 30) bus.event_i = {(n == 5 || n == 6), (n % 3 == 0)};
      else bus.event_i = {n[0], ~n[0]};
      tick();
      if (n == 29) check("lim_done_early", {31'd0, bus.done_o}, 0);
      if (n == 30) begin
        check("lim_done", {31'd0, bus.done_o}, 1);
        check("lim_cycle", {24'd0, bus.cycle_o}, 30);
      end
    end
    bus.event_i = 2'b00;
    check("lim_frozen", {24'd0, bus.cycle_o}, 30);
    snap();
    read(2'd1, 8'd10, "lim_ev0");
    read(2'd2, 8'd2, "lim_ev1");
    read(2'd0, 8'd30, "lim_sel0");
    read(2'd3, 8'd0, "lim_sel_oob");

    // 5b. Clear in DONE with start held resumes from 0
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    check("clr_done_low", {31'd0, bus.done_o}, 0);
    check("clr_done_cyc", {24'd0, bus.cycle_o}, 0);
    tick();
    check("clr_resume", {24'd0, bus.cycle_o}, 1);

    // 3. Overflow
    do_reset();
    bus.start_i = 1'b1;
    tick();
    bus.event_i = 2'b01;
    for (int n = 1; n <= 260; n++) begin
      tick();
      if (n == 255) check("ovf_pre", {29'd0, bus.ovf_o}, 0);
    end
    check("ovf_cycle", {24'd0, bus.cycle_o}, {24'd0, ovf_cnt});
    check("ovf_flags", {29'd0, bus.ovf_o}, 3'b011);
    bus.start_i = 1'b0;
    bus.event_i = 2'b00;
    tick();
    snap();
    read(2'd1, ovf_cnt, "ovf_ev0");

    // 4. Snapshot isolation
    do_reset();
    bus.start_i = 1'b1;
    tick();
    for (int n = 0; n < 10; n++) tick();
    snap();
    for (int n = 0; n < 9; n++) tick();
    check("snap_live", {24'd0, bus.cycle_o}, 20);
    read(2'd0, 8'd10, "snap_sel0");

    // 5a. Clear beats same-cycle events; snap with clear captures pre-clear values
    do_reset();
    bus.start_i = 1'b1;
    tick();
    bus.event_i = 2'b11;
    for (int n = 0; n < 5; n++) tick();
    bus.clear_i = 1'b1;
    bus.snap_i  = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    bus.snap_i  = 1'b0;
    bus.event_i = 2'b00;
    bus.start_i = 1'b0;
    check("clr_cycle", {24'd0, bus.cycle_o}, 0);
    tick();
    read(2'd1, 8'd5, "clr_preclr_ev0");
    snap();
    read(2'd1, 8'd0, "clr_ev0");
    read(2'd2, 8'd0, "clr_ev1");

    // 6. Pause / resume, then lower limit to the current count
    do_reset();
    bus.start_i = 1'b1;
    tick();
    bus.event_i = 2'b11;
    for (int n = 0; n < 7; n++) tick();
    bus.start_i = 1'b0;
    for (int n = 0; n < 5; n++) tick();
    check("pause_hold", {24'd0, bus.cycle_o}, 7);
    bus.start_i = 1'b1;
    tick();
    tick();
    check("pause_resume", {24'd0, bus.cycle_o}, 8);
    bus.limit_i = 8'd8;
    tick();
    check("lim_low_done", {31'd0, bus.done_o}, 1);
    check("lim_low_cycle", {24'd0, bus.cycle_o}, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/perf_monitor.md
# perf_monitor

Synthesizable, parametrised performance-monitor block for the pipelined CPU. It counts cycles and up to `NUM_EVENTS` single-bit pipeline events, for example IF stall, IF flush and dcache miss. It can stop itself after a programmable cycle limit and exposes a snapshot-buffered read port. It sits beside `CPU`, fed by hazard/cache status wires, so that cycle, stall and flush statistics come from hardware counters rather than bench-side bookkeeping.

## Interface
- `NUM_EVENTS`, 2: number of event counters (1–16).
- `CNT_WIDTH`, 32: width of every counter and of `limit_i`.
- `SEL_W`, derived `$clog2(NUM_EVENTS+1)`: read-select width.

- `clk_i` in 1: single clock; all state updates on posedge.
- `rst_i` in 1: synchronous, active-low reset.
- `start_i` in 1: counting enable, level-sensitive.
- `event_i` in `NUM_EVENTS`: bit k high means event k occurred this cycle.
- `limit_i` in `CNT_WIDTH`: cycle limit; 0 means unlimited.
- `clear_i` in 1: synchronous clear of counters, overflow flags and done.
- `snap_i` in 1: copy all live counters into the shadow bank.
- `sel_i` in `SEL_W`: read select. 0 is the cycle counter; k (1..`NUM_EVENTS`) is event k-1.
- `rd_data_o` out `CNT_WIDTH`: shadow-bank value selected by `sel_i`, registered.
- `cycle_o` out `CNT_WIDTH`: live cycle counter.
- `done_o` out 1: cycle limit reached; counting frozen.
- `ovf_o` out `NUM_EVENTS+1`: sticky overflow flags. Bit 0 is the cycle counter; bit k is event k-1.

## Operation
- Three-state FSM: IDLE, RUN, DONE.
- Reset (`rst_i`=0 at a posedge):
  - State goes to IDLE.
  - All live and shadow counters are 0.
  - `rd_data_o`=0, `cycle_o`=0, `done_o`=0, `ovf_o`=0.
- IDLE:
  - Counters hold.
  - `start_i`=1 moves to RUN; counting begins on the following edge.
- RUN:
  - Each posedge: cycle counter +1; event counter k +1 if `event_i[k]`.
  - `start_i`=0 returns to IDLE with counts held (pause/resume).
- Limit:
  - When `limit_i`≠0 and the incremented cycle count equals `limit_i`, go to DONE.
  - Events in that final cycle are counted.
  - If `limit_i` is changed while running to a value at or below the current count (nonzero), go to DONE on the next edge without counting that cycle.
- DONE:
  - `done_o`=1 and all counters frozen.
  - Exit only via `clear_i` or reset.
- `clear_i`:
  - Zeroes live counters, `ovf_o` and `done_o`.
  - Next state is RUN if `start_i`=1, else IDLE.
  - Clear wins over same-cycle events, limit match and overflow.
  - Shadow bank is unaffected.
- `snap_i`:
  - Shadow bank takes the pre-increment live values of that edge.
  - `snap_i` together with `clear_i` captures the pre-clear values.
- Overflow:
  - Increment from all-ones wraps to 0 and sets the sticky `ovf_o` bit.
  - With `PERF_MON_SATURATE_EN` the counter holds all-ones instead (see Configuration).
- Read: `sel_i` > `NUM_EVENTS` returns 0.

## Timing
- Event to counter: the count is visible on `cycle_o` (and in the shadow via snap) one edge after `event_i` is sampled.
- `rd_data_o` latency is 1 cycle from `sel_i`. A snap at edge N is readable on `rd_data_o` after edge N+1.
- `done_o` rises on the same edge where the cycle count reaches `limit_i`.
- Inputs sampled only at posedge; no combinational input-to-output path.

## Configuration
- `PERF_MON_SATURATE_EN` defined: all counters saturate at 2^`CNT_WIDTH`−1; `ovf_o` is still set on the first attempted increment past all-ones.
- Undefined: counters wrap modulo 2^`CNT_WIDTH`; `ovf_o` is set on the wrap.

## Test plan
All scenarios use `NUM_EVENTS`=2 and `CNT_WIDTH`=8.
1. Reset: hold `rst_i`=0 for 2 cycles with `event_i`=2'b11 and `start_i`=1 → all counters 0, `done_o`=0, `ovf_o`=0, `rd_data_o`=0.
2. Limit stop:
   - Stimulus: `limit_i`=30, `start_i`=1; `event_i[0]` every 3rd cycle; `event_i[1]` on cycles 5 and 6; events keep toggling after the limit.
   - Response: `done_o`=1 at cycle 30; `cycle_o`=30; snap then read sel 1 = 10 and sel 2 = 2; later events are ignored.
3. Overflow: `limit_i`=0, `event_i[0]`=1 for 260 cycles.
   - Without the macro: sel 1 reads 4 and `ovf_o[1]`=1.
   - With the macro: sel 1 reads 255 and `ovf_o[1]`=1.
   - In both builds the cycle counter also hits 4/255 with `ovf_o[0]`=1.
4. Snapshot isolation: pulse `snap_i` at cycle 10, run 10 more cycles → sel 0 reads 10 while `cycle_o`=20.
5. Clear priority:
   - Assert `clear_i` together with `event_i`=2'b11 in RUN → both event counters 0.
   - Assert `clear_i` in DONE with `start_i`=1 → `done_o`=0 and counting resumes from 0 next edge.
6. Pause: drop `start_i` at cycle 7 for 5 cycles with events active → `cycle_o` holds 7; counting resumes on reassert.
